// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing one GMII transmit MAC between N frame sources.
// Latches the winner's header, muxes its byte stream, enforces IFG and stall timeout.
`timescale 1ns/1ps
module tx_frame_arbiter #(
   parameter int N          = 2,
   parameter int OCT        = 8,
   parameter int IFG_CYCLES = 12,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 TX_CLK,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   input  logic [N*OCT*6-1:0]   src_mac_dst,
   input  logic [N*OCT*2-1:0]   src_len_type,
   input  logic [N*OCT-1:0]     src_data,
   input  logic [N-1:0]         src_valid,
   input  logic [N-1:0]         src_last,
   output logic [N-1:0]         src_ready,
   output logic                 tx_start,
   output logic [OCT*6-1:0]     tx_mac_dst,
   output logic [OCT*2-1:0]     tx_len_type,
   output logic [OCT-1:0]       tx_data,
   output logic                 tx_valid,
   output logic                 tx_last,
   input  logic                 tx_ready,
   output logic                 tx_abort,
   output logic                 busy
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_IFG} state_t;

   state_t           r_state, w_state_nxt;
   logic [SW-1:0]    r_sel, r_rr_ptr, w_winner;
   logic             w_any_req;
   logic [7:0]       r_ifg_cnt;
   logic [15:0]      r_stall;
   logic             r_tx_start, r_tx_abort;
   logic [OCT*6-1:0] r_mac_dst;
   logic [OCT*2-1:0] r_len_type;
   logic             w_streaming, w_xfer, w_grant, w_end, w_timeout;
   logic [N-1:0]     w_src_ready, w_gnt;

   // Lowest offset from rr_ptr is assigned last, so it wins.
   always_comb begin
      int unsigned idx;
      w_winner  = '0;
      w_any_req = 1'b0;
      idx       = 0;
      for (int unsigned k = N; k > 0; k--) begin
         idx = (32'(r_rr_ptr) + k) % N;
         if (req[idx]) begin
            w_winner  = SW'(idx);
            w_any_req = 1'b1;
         end
      end
   end

   assign w_streaming = (r_state == S_STREAM);
   assign tx_valid    = w_streaming & src_valid[r_sel];
   assign tx_last     = w_streaming & src_last[r_sel];
   assign tx_data     = w_streaming ? src_data[32'(r_sel)*OCT +: OCT] : '0;
   assign w_xfer      = tx_valid & tx_ready;

   always_comb begin
      w_src_ready = '0;
      w_gnt       = '0;
      if (w_streaming) begin
         w_src_ready[r_sel] = tx_ready;
         w_gnt[r_sel]       = 1'b1;
      end
   end

   assign src_ready   = w_src_ready;
   assign gnt         = w_gnt;
   assign tx_start    = r_tx_start;
   assign tx_abort    = r_tx_abort;
   assign tx_mac_dst  = r_mac_dst;
   assign tx_len_type = r_len_type;
   assign busy        = (r_state != S_IDLE);

   always_ff @(posedge TX_CLK) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_end       = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_grant     = 1'b1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_xfer && tx_last) begin
               w_end       = 1'b1;
               w_state_nxt = S_IFG;
            end else if (!src_valid[r_sel] && (r_stall == 16'(TIMEOUT - 1))) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IFG;
            end
         end
         S_IFG: begin
            if (r_ifg_cnt == 8'd0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge TX_CLK) begin
      if (rst) begin
         r_sel      <= '0;
         r_rr_ptr   <= SW'(N - 1);
         r_ifg_cnt  <= '0;
         r_stall    <= '0;
         r_tx_start <= 1'b0;
         r_tx_abort <= 1'b0;
         r_mac_dst  <= '0;
         r_len_type <= '0;
      end else begin
         r_tx_start <= w_grant;
         r_tx_abort <= w_timeout;
         if (w_grant) begin
            r_sel      <= w_winner;
            r_mac_dst  <= src_mac_dst[32'(w_winner)*(OCT*6) +: OCT*6];
            r_len_type <= src_len_type[32'(w_winner)*(OCT*2) +: OCT*2];
            r_stall    <= '0;
         end
         if (w_end || w_timeout) begin
            r_rr_ptr  <= r_sel;
            r_ifg_cnt <= 8'(IFG_CYCLES - 1);
            r_stall   <= '0;
         end else if (w_streaming) begin
            // Backpressure (valid high, ready low) holds the count.
            if (w_xfer)                  r_stall <= '0;
            else if (!src_valid[r_sel])  r_stall <= r_stall + 16'd1;
         end else if (r_state == S_IFG && r_ifg_cnt != 8'd0) begin
            r_ifg_cnt <= r_ifg_cnt - 8'd1;
         end
      end
   end

endmodule
